// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM states,
// bubble encoding and PC arithmetic helpers.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Redirect targets are word addresses; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid_buffer.sv
// One-entry {instruction, pc} holding register that parks a fetch response
// while decode is stalled.
module if_skid_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // Entry register; clear wins over load so a redirect always empties it.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_valid <= 1'b0;
            r_instr <= INSTR_BUBBLE;
            r_pc    <= 32'h0000_0000;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding word read at a time and
// drives the IF/ID register, handling stalls, wait states and redirects.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_read,
    output logic [31:0] o_imem_address,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_readdata,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_out,
    output logic        o_if_valid
);

    if_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_imem_read;
    logic [31:0] r_imem_address;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;

    if_state_e   w_state_next;
    logic [31:0] w_pc_next;
    logic        w_read_next;
    logic [31:0] w_addr_next;
    logic [31:0] w_instr_next;
    logic [31:0] w_pc_out_next;
    logic        w_valid_next;
    logic        w_skid_load;
    logic        w_skid_unload;
    logic        w_skid_clear;
    logic        w_skid_valid;
    logic [31:0] w_skid_instr;
    logic [31:0] w_skid_pc;
    logic [31:0] w_pc_inc;
    logic [31:0] w_target;

    assign w_pc_inc = r_pc + PC_STEP;
    assign w_target = word_align(i_branch_target);

    if_skid_buffer u_skid (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_instr  (i_imem_readdata),
        .i_pc     (r_pc),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    // Next-state, request and IF/ID selection; redirect outranks stall.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_read_next   = r_imem_read;
        w_addr_next   = r_imem_address;
        w_instr_next  = r_instr;
        w_pc_out_next = r_pc_out;
        w_valid_next  = r_valid;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_clear  = 1'b0;
        if (i_branch_taken) begin
            w_instr_next  = INSTR_BUBBLE;
            w_pc_out_next = 32'h0000_0000;
            w_valid_next  = 1'b0;
            w_skid_clear  = 1'b1;
            w_pc_next     = w_target;
            // An unanswered request must keep its address until memory responds.
            if (r_imem_read && !i_imem_ready) begin
                w_state_next = ST_DRAIN;
            end else begin
                w_state_next = ST_FETCH;
                w_read_next  = 1'b1;
                w_addr_next  = w_target;
            end
        end else begin
            if (!i_stall) begin
                w_instr_next  = INSTR_BUBBLE;
                w_pc_out_next = 32'h0000_0000;
                w_valid_next  = 1'b0;
            end else begin
                w_valid_next  = r_valid;
            end
            case (r_state)
                ST_FETCH: begin
                    if (i_imem_ready && i_stall) begin
                        w_skid_load  = 1'b1;
                        w_read_next  = 1'b0;
                        w_state_next = ST_HOLD;
                    end else if (i_imem_ready) begin
                        w_instr_next  = i_imem_readdata;
                        w_pc_out_next = r_pc;
                        w_valid_next  = 1'b1;
                        w_pc_next     = w_pc_inc;
                        w_addr_next   = w_pc_inc;
                    end else begin
                        w_state_next = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (!i_stall && w_skid_valid) begin
                        w_skid_unload = 1'b1;
                        w_instr_next  = w_skid_instr;
                        w_pc_out_next = w_skid_pc;
                        w_valid_next  = 1'b1;
                        w_pc_next     = w_pc_inc;
                        w_read_next   = 1'b1;
                        w_addr_next   = w_pc_inc;
                        w_state_next  = ST_FETCH;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (i_imem_ready) begin
                        w_read_next  = 1'b1;
                        w_addr_next  = r_pc;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_DRAIN;
                    end
                end
                default: begin
                    w_read_next  = 1'b1;
                    w_addr_next  = r_pc;
                    w_state_next = ST_FETCH;
                end
            endcase
        end
    end

    // State, PC, request and IF/ID registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_FETCH;
            r_pc           <= RESET_PC;
            r_imem_read    <= 1'b1;
            r_imem_address <= RESET_PC;
            r_instr        <= INSTR_BUBBLE;
            r_pc_out       <= 32'h0000_0000;
            r_valid        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_imem_read    <= w_read_next;
            r_imem_address <= w_addr_next;
            r_instr        <= w_instr_next;
            r_pc_out       <= w_pc_out_next;
            r_valid        <= w_valid_next;
        end
    end

    assign o_imem_read    = r_imem_read;
    assign o_imem_address = r_imem_address;
    assign o_instruction  = r_instr;
    assign o_pc_out       = r_pc_out;
    assign o_if_valid     = r_valid;

endmodule
